// File: rtl/ofmap_wraddr_gen.sv
// rtl/ofmap_wraddr_gen.sv - output feature map write-address generator
// Optional ReLU on write data when OFMAP_RELU_EN is defined.
module ofmap_wraddr_gen #(
    parameter int OUT_FEATURE_WIDTH = 24,
    parameter int NUM_OUTMAP        = 6,
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = (OUT_FEATURE_WIDTH > 1) ? $clog2(OUT_FEATURE_WIDTH) : 1;
    localparam int MW = (NUM_OUTMAP > 1) ? $clog2(NUM_OUTMAP) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_FEATURE_WIDTH - 1);
    localparam logic [MW-1:0] MAP_LAST = MW'(NUM_OUTMAP - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  state_q;
    logic [CW-1:0]           col_q, col_d, row_q, row_d;
    logic [MW-1:0]           map_q, map_d;
    logic [ADDR_WIDTH-1:0]   addr_q, mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, wdata_d;
    logic                    in_ready_q, mem_we_q, busy_q, done_q;
    logic                    accept, last_pix;

    assign accept   = in_valid && in_ready_q;
    assign last_pix = (col_q == COL_LAST) && (row_q == COL_LAST) && (map_q == MAP_LAST);

`ifdef OFMAP_RELU_EN
    assign wdata_d = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    assign wdata_d = in_data;
`endif

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        map_d = map_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == COL_LAST) begin
                row_d = '0;
                map_d = (map_q == MAP_LAST) ? '0 : map_q + MW'(1);
            end else begin
                row_d = row_q + CW'(1);
            end
        end else begin
            col_d = col_q + CW'(1);
        end
    end

    // Pixel order is linear in memory, so the address simply counts up from base.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            map_q       <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_we_q <= accept;
            done_q   <= 1'b0;
            if (accept) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= wdata_d;
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                col_q       <= col_d;
                row_q       <= row_d;
                map_q       <= map_d;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        addr_q     <= base_addr;
                        col_q      <= '0;
                        row_q      <= '0;
                        map_q      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept && last_pix) begin
                        state_q    <= FLUSH;
                        in_ready_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    // done lands in the cycle after the final write is on the bus.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
